// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: resolves load-use, leap and
// multi-cycle multiply hazards, and keeps saturating stall/flush event counters.
module pipe_hazard_ctrl #(
    parameter int MUL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_useRs1,
    input  logic        id_useRs2,
    input  logic        ex_valid,
    input  logic [4:0]  ex_destReg,
    input  logic        ex_RegWrite,
    input  logic        ex_MemToReg,
    input  logic        ex_mul,
    input  logic        leap,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_en,
    output logic        idex_flush,
    output logic        exmem_bubble,
    output logic        mul_busy,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    localparam logic       ST_IDLE      = 1'b0;
    localparam logic       ST_BUSY      = 1'b1;
    localparam logic       MUL_STALL_EN = (MUL_CYCLES > 1);
    localparam logic [3:0] MCNT_INIT    = 4'(MUL_CYCLES - 2);

    logic        state_q, state_d;
    logic [3:0]  mcnt_q, mcnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    logic mul_start, mul_stall, lu, leap_ev, rs1_hit, rs2_hit;

    always_comb begin
        rs1_hit   = id_useRs1 && (id_rs1 == ex_destReg);
        rs2_hit   = id_useRs2 && (id_rs2 == ex_destReg);
        lu        = ex_valid && ex_MemToReg && ex_RegWrite && (ex_destReg != 5'd0)
                    && (rs1_hit || rs2_hit);
        leap_ev   = leap && ex_valid;
        mul_start = (state_q == ST_IDLE) && ex_valid && ex_mul && MUL_STALL_EN;
        mul_stall = mul_start || ((state_q == ST_BUSY) && (mcnt_q != 4'd0));
    end

    // The FSM advances even under a leap; a leap only overrides the outputs.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        mcnt_d  = mcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (mul_start) begin
                    state_d = ST_BUSY;
                    mcnt_d  = MCNT_INIT;
                end
            end
            default: begin
                if (mcnt_q != 4'd0) begin
                    mcnt_d = mcnt_q - 4'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_flush   = 1'b0;
        exmem_bubble = 1'b0;
        if (reset) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            exmem_bubble = 1'b1;
        end else if (leap_ev) begin
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
        end else if (mul_stall) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_bubble = 1'b1;
        end else if (lu) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_flush   = 1'b1;
        end
    end

    // A stall is only counted when it wins; a leap squashes any dependent instruction.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!leap_ev && (mul_stall || lu) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (leap_ev && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mcnt_q      <= 4'd0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q     <= state_d;
            mcnt_q      <= mcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mul_busy  = (state_q == ST_BUSY) && !reset;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic,
// checked against a model that tracks each multiply's cycle position in EX.
module tb_pipe_hazard_ctrl;

    localparam int N = 4;

    logic        clk;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2;
    logic        id_useRs1, id_useRs2;
    logic        ex_valid;
    logic [4:0]  ex_destReg;
    logic        ex_RegWrite, ex_MemToReg, ex_mul, leap;
    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_bubble, mul_busy;
    logic [15:0] stall_cnt, flush_cnt;

    pipe_hazard_ctrl #(.MUL_CYCLES(N)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_useRs1(id_useRs1), .id_useRs2(id_useRs2),
        .ex_valid(ex_valid), .ex_destReg(ex_destReg), .ex_RegWrite(ex_RegWrite),
        .ex_MemToReg(ex_MemToReg), .ex_mul(ex_mul), .leap(leap),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_flush(idex_flush), .exmem_bubble(exmem_bubble), .mul_busy(mul_busy),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: position (1..N) of the multiply that was in EX last cycle, 0 if none.
    int mpos      = 0;
    int stall_ref = 0;
    int flush_ref = 0;
    bit ref_valid = 1'b0;

    logic last_pc_en, last_idex_flush, last_ifid_flush, last_mul_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        reset = 1'b0; id_rs1 = '0; id_rs2 = '0; id_useRs1 = 1'b0; id_useRs2 = 1'b0;
        ex_valid = 1'b0; ex_destReg = '0; ex_RegWrite = 1'b0; ex_MemToReg = 1'b0;
        ex_mul = 1'b0; leap = 1'b0;
    endtask

    task automatic load_use(input logic [4:0] dst);
        ex_valid = 1'b1; ex_MemToReg = 1'b1; ex_RegWrite = 1'b1; ex_destReg = dst;
        id_rs2 = dst; id_useRs2 = 1'b1;
    endtask

    // One clock: compare at the falling edge, then advance the model at the rising edge.
    task automatic tick();
        int pos;
        bit lu_e, leap_e, mstall, idex_care;
        logic e_pc, e_ifen, e_iff, e_iden, e_idf, e_bub, e_busy;
        @(negedge clk);
        leap_e = leap && ex_valid;
        lu_e   = ex_valid && ex_MemToReg && ex_RegWrite && (ex_destReg != 0)
                 && ((id_useRs1 && id_rs1 == ex_destReg) || (id_useRs2 && id_rs2 == ex_destReg));
        if (reset) pos = 0;
        else if (mpos > 0 && mpos < N) pos = mpos + 1;
        else pos = (ex_valid && ex_mul) ? 1 : 0;
        mstall    = !reset && pos > 0 && pos < N;
        e_busy    = !reset && pos >= 2;
        idex_care = 1'b1;
        if (reset) begin
            {e_pc, e_ifen, e_iden, e_iff, e_idf, e_bub} = 6'b000111;
        end else if (leap_e) begin
            {e_pc, e_ifen, e_iden, e_iff, e_idf, e_bub} = 6'b111110;
            idex_care = 1'b0;
        end else if (mstall) begin
            {e_pc, e_ifen, e_iden, e_iff, e_idf, e_bub} = 6'b000001;
        end else if (lu_e) begin
            {e_pc, e_ifen, e_iden, e_iff, e_idf, e_bub} = 6'b001010;
            idex_care = 1'b0;
        end else begin
            {e_pc, e_ifen, e_iden, e_iff, e_idf, e_bub} = 6'b111000;
        end
        check("pc_en", 32'(pc_en), 32'(e_pc));
        check("ifid_en", 32'(ifid_en), 32'(e_ifen));
        check("ifid_flush", 32'(ifid_flush), 32'(e_iff));
        check("idex_flush", 32'(idex_flush), 32'(e_idf));
        check("exmem_bubble", 32'(exmem_bubble), 32'(e_bub));
        check("mul_busy", 32'(mul_busy), 32'(e_busy));
        if (idex_care) check("idex_en", 32'(idex_en), 32'(e_iden));
        if (ref_valid) begin
            check("stall_cnt", 32'(stall_cnt), 32'(stall_ref));
            check("flush_cnt", 32'(flush_cnt), 32'(flush_ref));
        end
        last_pc_en = pc_en; last_idex_flush = idex_flush;
        last_ifid_flush = ifid_flush; last_mul_busy = mul_busy;
        @(posedge clk);
        if (reset) begin
            mpos = 0; stall_ref = 0; flush_ref = 0; ref_valid = 1'b1;
        end else begin
            mpos = pos;
            if (leap_e) begin
                if (flush_ref < 65535) flush_ref++;
            end else if (mstall || lu_e) begin
                if (stall_ref < 65535) stall_ref++;
            end
        end
        #1;
    endtask

    initial begin
        logic [3:0] pc_pat, busy_pat;
        idle_inputs();

        // Reset held two cycles with a multiply presented.
        reset = 1'b1; ex_valid = 1'b1; ex_mul = 1'b1;
        tick();
        tick();
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
        idle_inputs();
        tick();
        check("post_rst_pc_en", 32'(last_pc_en), 32'd1);

        // Single multiply: stall in cycles 1-3, busy in cycles 2-4.
        ex_valid = 1'b1; ex_mul = 1'b1;
        for (int i = 0; i < N; i++) begin
            tick();
            pc_pat[i]   = last_pc_en;
            busy_pat[i] = last_mul_busy;
        end
        check("mul_pc_pattern", 32'(pc_pat), 32'b1000);
        check("mul_busy_pattern", 32'(busy_pat), 32'b1110);
        idle_inputs();
        tick();
        check("mul_stall_total", 32'(stall_cnt), 32'd3);

        // Back-to-back multiplies add six more stalls.
        ex_valid = 1'b1; ex_mul = 1'b1;
        repeat (2 * N) tick();
        idle_inputs();
        tick();
        check("b2b_stall_total", 32'(stall_cnt), 32'd9);

        // Load-use on r5 costs one cycle; r0 never hazards.
        load_use(5'd5);
        tick();
        check("lu_idex_flush", 32'(last_idex_flush), 32'd1);
        check("lu_pc_en", 32'(last_pc_en), 32'd0);
        ex_valid = 1'b0;
        tick();
        check("lu_release_pc_en", 32'(last_pc_en), 32'd1);
        idle_inputs();
        load_use(5'd0);
        tick();
        check("lu_r0_pc_en", 32'(last_pc_en), 32'd1);

        // Leap beats a simultaneous load-use.
        idle_inputs();
        load_use(5'd7);
        leap = 1'b1;
        tick();
        check("leap_ifid_flush", 32'(last_ifid_flush), 32'd1);
        check("leap_pc_en", 32'(last_pc_en), 32'd1);
        idle_inputs();
        tick();
        check("leap_flush_cnt", 32'(flush_cnt), 32'd1);
        check("leap_stall_cnt", 32'(stall_cnt), 32'd10);

        // Reset during cycle 2 of a multiply leaves no residual stall.
        ex_valid = 1'b1; ex_mul = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; ex_mul = 1'b0;
        tick();
        check("rst_mid_busy", 32'(last_mul_busy), 32'd0);
        check("rst_mid_pc_en", 32'(last_pc_en), 32'd1);

        // Saturation: preload near the top, then push past it.
        force dut.stall_cnt_q = 16'hFFFD;
        force dut.flush_cnt_q = 16'hFFFE;
        #1;
        release dut.stall_cnt_q;
        release dut.flush_cnt_q;
        stall_ref = 65533;
        flush_ref = 65534;
        idle_inputs();
        load_use(5'd3);
        repeat (3) tick();
        leap = 1'b1;
        repeat (2) tick();
        idle_inputs();
        tick();
        check("sat_stall_cnt", 32'(stall_cnt), 32'hFFFF);
        check("sat_flush_cnt", 32'(flush_cnt), 32'hFFFF);

        // Randomized traffic with small register numbers so hazards are frequent.
        reset = 1'b1;
        tick();
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 63) == 0);
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            id_useRs1   = 1'($urandom);
            id_useRs2   = 1'($urandom);
            ex_valid    = ($urandom_range(0, 7) != 0);
            ex_destReg  = 5'($urandom_range(0, 3));
            ex_RegWrite = 1'($urandom);
            ex_MemToReg = 1'($urandom);
            ex_mul      = ($urandom_range(0, 7) == 0);
            leap        = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the five-stage integer pipeline. Watches the ID and EX stages and drives the enable and flush controls of PC, IF/ID, ID/EX and EX/MEM. Handles three events:
- load-use hazards, by inserting a one-cycle bubble;
- taken branches and jumps (`leap` from the execute stage), by squashing the two younger stages;
- multi-cycle multiplies, by freezing the front end while the multiplier settles.

It also keeps saturating stall and flush event counters for performance debug.

## Interface
Parameters:
- `MUL_CYCLES`, default 4: total cycles a multiply occupies EX. Legal range 1–15. A value of 1 means no multiply stall.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `id_rs1`, `id_rs2` in [0:4]: source register numbers of the instruction in ID.
- `id_useRs1`, `id_useRs2` in 1: the ID instruction actually reads rs1 / rs2.
- `ex_valid` in 1: EX holds a real instruction, not a bubble.
- `ex_destReg` in [0:4]: destination register of the EX instruction.
- `ex_RegWrite`, `ex_MemToReg` in 1: the EX instruction writes a register / is a load.
- `ex_mul` in 1: the EX instruction is a multiply.
- `leap` in 1: taken branch or jump resolved in EX this cycle.
- `pc_en` out 1: PC register load enable. The PC mux selects `leapAddr` when `leap`.
- `ifid_en` out 1: IF/ID load enable.
- `ifid_flush` out 1: IF/ID loads a bubble.
- `idex_en` out 1: ID/EX load enable.
- `idex_flush` out 1: ID/EX loads a bubble. Overrides `idex_en`.
- `exmem_bubble` out 1: EX/MEM captures a bubble instead of the EX result.
- `mul_busy` out 1: the multiply FSM is not in IDLE.
- `stall_cnt` out [0:15]: saturating count of stall cycles.
- `flush_cnt` out [0:15]: saturating count of leap flushes.

## Operation
Multiply FSM:
- States are IDLE and BUSY. A 4-bit down-counter `mcnt` is used.
- IDLE → BUSY when `ex_valid & ex_mul` and `MUL_CYCLES > 1`. `mcnt` loads `MUL_CYCLES-2`. The stall is asserted in this same cycle.
- In BUSY with `mcnt != 0`: stall asserted, `mcnt` decrements.
- In BUSY with `mcnt == 0`: stall released, this is the final EX cycle, FSM returns to IDLE.
- `mul_stall` = (IDLE & `ex_valid` & `ex_mul` & `MUL_CYCLES>1`) | (BUSY & `mcnt!=0`).
- During `mul_stall`:
  - `pc_en`, `ifid_en` and `idex_en` are 0.
  - `exmem_bubble` is 1.
  - The EX contents are held, so `ex_mul` stays stable throughout.

Load-use hazard:
- `lu` = `ex_valid & ex_MemToReg & ex_RegWrite & (ex_destReg != 0)` & ((`id_useRs1` & `id_rs1 == ex_destReg`) | (`id_useRs2` & `id_rs2 == ex_destReg`)).
- Response: `pc_en` = 0, `ifid_en` = 0, `idex_flush` = 1, `exmem_bubble` = 0.
- The load proceeds; the bubble enters EX next cycle, so `lu` clears on its own after one cycle.

Leap:
- Triggered by `leap & ex_valid`.
- Response: `pc_en` = 1, `ifid_flush` = 1, `idex_flush` = 1, `exmem_bubble` = 0.
- The branching instruction itself continues to MEM.

Priority, highest first: `reset` > leap > `mul_stall` > `lu` > normal.
- `leap` and `mul_stall` are mutually exclusive by ISA, since a multiply is not a control transfer. If both are seen anyway, leap wins and the FSM still advances.
- Leap with `lu` set: leap wins and no stall is counted, because the dependent instruction is squashed.

Normal operation: `pc_en`, `ifid_en` and `idex_en` are 1; all flush/bubble outputs are 0.

Counters:
- `stall_cnt` increments on every cycle in which `mul_stall` or `lu` is the winning event.
- `flush_cnt` increments on every leap cycle.
- Both saturate at 16'hFFFF.

Reset:
- While `reset` is high:
  - `pc_en`, `ifid_en` and `idex_en` are 0.
  - `ifid_flush`, `idex_flush` and `exmem_bubble` are 1.
  - `mul_busy` is 0.
- On the first rising edge with `reset` high: FSM → IDLE, `mcnt` = 0, both counters = 0.
- Reset mid-multiply abandons the multiply. There is no residual stall after reset is released.

## Timing
- All outputs except the counters and `mul_busy` are combinational from the current inputs and state, and take effect at the next rising edge.
- Multiply with `MUL_CYCLES = N`:
  - the instruction occupies EX for N cycles;
  - it produces N-1 stall cycles;
  - the EX/MEM capture happens at the end of cycle N.
- `mul_busy` is high in cycles 2..N.
- Load-use costs exactly 1 cycle. Leap costs 2 squashed slots.
- Back-to-back multiplies: the second multiply enters EX the cycle after the first leaves, with the FSM in IDLE, and starts a fresh N-cycle sequence. No overlap occurs and no cycle is skipped.

## Test plan
- **Reset:** hold `reset` 2 cycles with `ex_mul = 1`.
  - During reset: `pc_en` = 0, flush outputs = 1, `mul_busy` = 0, counters 0.
  - First cycle after release with no hazards: `pc_en`, `ifid_en` and `idex_en` = 1.
- **Multiply:** `MUL_CYCLES = 4`, single multiply in EX.
  - `pc_en` = 0 for exactly cycles 1–3 and 1 in cycle 4.
  - `mul_busy` = 1 in cycles 2–4.
  - `stall_cnt` = 3 afterwards.
  - Repeat with back-to-back multiplies: 6 stall cycles total.
- **Load-use:** load in EX with `ex_destReg = 5`, ID has `id_rs2 = 5`, `id_useRs2 = 1` → one cycle of `idex_flush = 1` and `pc_en = 0`, then normal. Repeat with `ex_destReg = 0` → no stall.
- **Leap priority:** `leap = 1` with `lu` true in the same cycle → `ifid_flush = idex_flush = 1`, `pc_en = 1`, `flush_cnt` +1, `stall_cnt` unchanged.
- **Reset mid-multiply:** assert `reset` in cycle 2 of a 4-cycle multiply, release with a non-multiply in EX → FSM in IDLE, `mul_busy` = 0, no stall.
- **Saturation:** preload via 65 535 load-use stalls plus 2 more → `stall_cnt` = 16'hFFFF. Use a bench force of the counter if run time is a constraint.
